// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, frame geometry
// and the odd-parity helper used by the transmitter.
package ps2_pkg;

  localparam int FRAME_LEN = 11;
  localparam int BIT_IDX_W = 4;
  // Last bit index driven in SHIFT: d0..d7 plus parity.
  localparam int SHIFT_LAST = FRAME_LEN - 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SHIFT,
    S_STOP,
    S_ACK,
    S_WAIT_IDLE
  } ps2_tx_state_t;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one raw PS/2 pin plus edge detection
// on the synchronized level. Resets to the idle-high line level.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_fall,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchronizer chain and previous-sample register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_pin;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_fall  = r_prev & ~r_sync;
  assign o_rise  = ~r_prev & r_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift, ACK.
// Build option: PS2_TX_ACK_CHECK_EN enables the ACK state and NACK error.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 25000000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_MS = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int INHIBIT_CYCLES = CLK_HZ / 1000000 * INHIBIT_US;
  localparam int TIMEOUT_CYCLES = CLK_HZ / 1000 * TIMEOUT_MS;
  localparam int CNT_MAX =
    (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BIT_IDX_W-1:0] IDX_LAST = BIT_IDX_W'(SHIFT_LAST);

  ps2_tx_state_t r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [8:0]           r_shift, w_shift_nxt;
  logic [BIT_IDX_W-1:0] r_idx, w_idx_nxt;
  logic r_nack, w_nack_nxt;
  logic r_clk_oe, w_clk_oe_nxt;
  logic r_data_oe, w_data_oe_nxt;
  logic r_done, w_done_nxt;
  logic r_err, w_err_nxt;

  logic w_clk_lvl, w_clk_fall, w_clk_rise;
  logic w_dat_lvl, w_dat_fall, w_dat_rise;
  logic w_clk_edge;
  logic w_watch;

  ps2_sync_edge u_clk_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_pin   (ps2_clk_i),
    .o_level (w_clk_lvl),
    .o_fall  (w_clk_fall),
    .o_rise  (w_clk_rise)
  );

  ps2_sync_edge u_dat_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_pin   (ps2_data_i),
    .o_level (w_dat_lvl),
    .o_fall  (w_dat_fall),
    .o_rise  (w_dat_rise)
  );

  assign w_clk_edge = w_clk_fall | w_clk_rise;
  assign w_watch = (r_state != S_IDLE) && (r_state != S_INHIBIT);

  // State and registered-output flops; reset releases both lines at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_idx     <= '0;
      r_nack    <= 1'b0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_idx     <= w_idx_nxt;
      r_nack    <= w_nack_nxt;
      r_clk_oe  <= w_clk_oe_nxt;
      r_data_oe <= w_data_oe_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
    end
  end

  // Next-state, shift and line-drive logic with the device-clock watchdog.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_shift_nxt   = r_shift;
    w_idx_nxt     = r_idx;
    w_nack_nxt    = r_nack;
    w_clk_oe_nxt  = r_clk_oe;
    w_data_oe_nxt = r_data_oe;
    w_done_nxt    = 1'b0;
    w_err_nxt     = 1'b0;
    if (w_watch) begin
      w_cnt_nxt = w_clk_edge ? '0 : r_cnt + CNT_W'(1);
    end
    unique case (r_state)
      S_IDLE: begin
        w_clk_oe_nxt  = 1'b0;
        w_data_oe_nxt = 1'b0;
        if (tx_valid) begin
          w_shift_nxt  = {odd_parity(tx_data), tx_data};
          w_cnt_nxt    = '0;
          w_idx_nxt    = '0;
          w_nack_nxt   = 1'b0;
          w_clk_oe_nxt = 1'b1;
          w_state_nxt  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        w_clk_oe_nxt = 1'b1;
        w_cnt_nxt    = r_cnt + CNT_W'(1);
        if (r_cnt == INH_LAST) begin
          w_cnt_nxt     = '0;
          w_data_oe_nxt = 1'b1;
          w_state_nxt   = S_RTS;
        end
      end
      S_RTS: begin
        w_clk_oe_nxt  = 1'b0;
        w_data_oe_nxt = 1'b1;
        w_idx_nxt     = '0;
        w_cnt_nxt     = '0;
        w_state_nxt   = S_SHIFT;
      end
      S_SHIFT: begin
        if (w_clk_fall) begin
          w_data_oe_nxt = ~r_shift[0];
          w_shift_nxt   = {1'b0, r_shift[8:1]};
          w_idx_nxt     = r_idx + BIT_IDX_W'(1);
          if (r_idx == IDX_LAST) begin
            w_state_nxt = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (w_clk_fall) begin
          w_data_oe_nxt = 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
          w_state_nxt = S_ACK;
`else
          w_state_nxt = S_WAIT_IDLE;
`endif
        end
      end
      S_ACK: begin
        if (w_clk_fall) begin
          w_state_nxt = S_WAIT_IDLE;
          if (w_dat_lvl) begin
            w_err_nxt  = 1'b1;
            w_nack_nxt = 1'b1;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (w_clk_lvl && w_dat_lvl) begin
          w_done_nxt  = ~r_nack;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_watch && !w_clk_edge && (r_cnt == TO_LAST)) begin
      w_err_nxt     = 1'b1;
      w_done_nxt    = 1'b0;
      w_clk_oe_nxt  = 1'b0;
      w_data_oe_nxt = 1'b0;
      w_cnt_nxt     = '0;
      w_state_nxt   = S_IDLE;
    end
  end

  assign tx_ready    = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign error       = r_err;
  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;

  logic w_unused;
  assign w_unused = w_dat_fall ^ w_dat_rise;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device
// clocking at 40 us over wired-AND open-drain lines.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int CLK_HZ  = 1000000;
  localparam int INH_US  = 100;
  localparam int TO_MS   = 1;
  localparam int INH_CYC = 100;
  localparam int TO_CYC  = 1000;
  localparam int HALF    = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, done, error;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       pin_clk, pin_data;

  int n_chk = 0;
  int n_fail = 0;
  int n_done = 0;
  int n_err = 0;
  int n_both = 0;

  assign pin_clk  = ~(ps2_clk_oe | dev_clk_low);
  assign pin_data = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .CLK_HZ     (CLK_HZ),
    .INHIBIT_US (INH_US),
    .TIMEOUT_MS (TO_MS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .ps2_clk_i   (pin_clk),
    .ps2_data_i  (pin_data),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  always #500 clk = ~clk;

  always @(negedge clk) begin
    if (done) n_done++;
    if (error) n_err++;
    if (done && error) n_both++;
  end

  initial begin
    #40ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_rts(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (ps2_data_oe && !ps2_clk_oe) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic dev_frame(input bit ack, input int npulse,
                           output logic [10:0] bits);
    bits = '0;
    bits[0] = pin_data;
    for (int i = 1; i <= npulse; i++) begin
      if (i == 11 && ack) dev_data_low = 1'b1;
      repeat (2) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      if (i <= 10) bits[i] = pin_data;
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
      if (i == 11) dev_data_low = 1'b0;
    end
  endtask

  task automatic clr_counts();
    n_done = 0;
    n_err  = 0;
  endtask

  initial begin
    logic [10:0] bits;
    logic [7:0]  d;
    int cnt;

    repeat (3) @(negedge clk);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 0xED with ACK, plus inhibit / RTS timing
    clr_counts();
    send(8'hED);
    check("ed_busy", 32'(busy), 32'd1);
    check("ed_ready", 32'(tx_ready), 32'd0);
    check("ed_clk_oe", 32'(ps2_clk_oe), 32'd1);
    check("ed_data_oe0", 32'(ps2_data_oe), 32'd0);
    cnt = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (ps2_data_oe) begin
        cnt = i;
        break;
      end
    end
    check("inhibit_len", 32'(cnt), 32'(INH_CYC));
    check("rts_clk_held", 32'(ps2_clk_oe), 32'd1);
    @(negedge clk);
    check("rts_clk_rel", 32'(ps2_clk_oe), 32'd0);
    wait_rts("ed_rts");
    dev_frame(1'b1, 11, bits);
    repeat (10) @(negedge clk);
    check("ed_bits", 32'(bits), 32'(11'b11_1110_1101_0));
    check("ed_done", 32'(n_done), 32'd1);
    check("ed_err", 32'(n_err), 32'd0);
    check("ed_ready_end", 32'(tx_ready), 32'd1);

    // 0xF4: parity bit 0
    clr_counts();
    send(8'hF4);
    wait_rts("f4_rts");
    dev_frame(1'b1, 11, bits);
    repeat (10) @(negedge clk);
    check("f4_bits", 32'(bits), 32'(frame_of(8'hF4)));
    check("f4_parity", 32'(bits[9]), 32'd0);
    check("f4_done", 32'(n_done), 32'd1);
    check("f4_err", 32'(n_err), 32'd0);

    // device leaves data high on the 11th edge
    clr_counts();
    send(8'h03);
    wait_rts("nack_rts");
    dev_frame(1'b0, 11, bits);
    repeat (10) @(negedge clk);
    check("nack_bits", 32'(bits), 32'(frame_of(8'h03)));
`ifdef PS2_TX_ACK_CHECK_EN
    check("nack_err", 32'(n_err), 32'd1);
    check("nack_done", 32'(n_done), 32'd0);
`else
    check("noack_err", 32'(n_err), 32'd0);
    check("noack_done", 32'(n_done), 32'd1);
`endif

    // device stops clocking after d3
    clr_counts();
    send(8'h12);
    wait_rts("to_rts");
    dev_frame(1'b0, 4, bits);
    check("to_partial", 32'(bits[4:0]), 32'(5'b0010_0));
    cnt = 0;
    for (int i = 1; i <= TO_CYC + 200; i++) begin
      @(negedge clk);
      if (n_err != 0) begin
        cnt = i;
        break;
      end
    end
    check("to_seen", 32'(cnt != 0), 32'd1);
    check("to_err", 32'(n_err), 32'd1);
    check("to_done", 32'(n_done), 32'd0);
    check("to_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("to_data_oe", 32'(ps2_data_oe), 32'd0);
    check("to_ready", 32'(tx_ready), 32'd1);

    // 0x55 request while 0x00 is in flight is dropped
    clr_counts();
    send(8'h00);
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    repeat (5) @(negedge clk);
    tx_valid = 1'b0;
    wait_rts("ign_rts");
    dev_frame(1'b1, 11, bits);
    repeat (10) @(negedge clk);
    check("ign_bits", 32'(bits), 32'(11'b11_0000_0000_0));
    check("ign_done", 32'(n_done), 32'd1);
    repeat (300) @(negedge clk);
    check("ign_no_resend", 32'(busy), 32'd0);
    check("ign_clk_oe", 32'(ps2_clk_oe), 32'd0);

    // asynchronous reset in SHIFT, then 0xFF
    clr_counts();
    send(8'hAA);
    wait_rts("rst_rts");
    dev_frame(1'b1, 3, bits);
    check("pre_rst_data_oe", 32'(ps2_data_oe), 32'd1);
    #200;
    rst_n = 1'b0;
    #1;
    check("async_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("async_data_oe", 32'(ps2_data_oe), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(tx_ready), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);
    clr_counts();
    send(8'hFF);
    wait_rts("ff_rts");
    dev_frame(1'b1, 11, bits);
    repeat (10) @(negedge clk);
    check("ff_bits", 32'(bits), 32'(11'b11_1111_1111_0));
    check("ff_done", 32'(n_done), 32'd1);
    check("ff_err", 32'(n_err), 32'd0);
    check("never_both", 32'(n_both), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter for the MSX core: it sends command bytes to the keyboard on the same two open-drain lines the PS/2 receiver listens to. Typical traffic is 0xED plus an LED mask for CAPS/KANA, 0xFF for reset and 0xF4 to enable scanning. The block sequences the inhibit, request-to-send, bit shifting and ACK phases. It drives the lines only as open-drain pull-low enables and flags `busy` so the receiver can discard edges generated during a transmission.

## Interface
Parameters:
- `CLK_HZ`, 25000000: system clock frequency.
- `INHIBIT_US`, 100: time the clock line is held low before the request-to-send. `INHIBIT_CYCLES = CLK_HZ/1000000*INHIBIT_US`, which is 2500 at defaults.
- `TIMEOUT_MS`, 20: maximum gap between device clock edges. `TIMEOUT_CYCLES = CLK_HZ/1000*TIMEOUT_MS`.

Ports:
- `clk` input 1: system clock (cpuClock domain).
- `rst_n` input 1: asynchronous, active-low reset.
- `tx_data` input 8: byte to send. Sampled when `tx_valid && tx_ready`.
- `tx_valid` input 1: send request.
- `tx_ready` output 1: high only in IDLE.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse when the device has accepted the byte.
- `error` output 1: one-cycle pulse on timeout or NACK.
- `ps2_clk_i` input 1: raw PS/2 clock pin level (asynchronous).
- `ps2_data_i` input 1: raw PS/2 data pin level (asynchronous).
- `ps2_clk_oe` output 1: 1 pulls the clock line low.
- `ps2_data_oe` output 1: 1 pulls the data line low.

## Operation
- Both inputs pass through a 2-FF synchronizer. A falling edge (`fall`) means the synchronized previous sample was 1 and the current sample is 0.
- The frame is shifted in this order: start bit 0, `d0..d7` (LSB first), odd parity (`~^tx_data`), stop bit 1.
- States and transitions:
  - IDLE: both oe outputs 0. On accept, latch `{parity, tx_data}` into the shift register, clear the counter, go to INHIBIT.
  - INHIBIT: `ps2_clk_oe=1`; the counter counts up. At `INHIBIT_CYCLES-1` set `ps2_data_oe=1` and go to RTS.
  - RTS: in this cycle, release `ps2_clk_oe` (0) and keep `ps2_data_oe=1`. Bit index is 0. Clear the counter and go to SHIFT.
  - SHIFT: on each `fall`, `ps2_data_oe <= ~shift[0]`, shift right, and increment the index. When the index reaches 9 (8 data bits plus parity have been driven), go to STOP.
  - STOP: on `fall`, set `ps2_data_oe=0` (stop bit released) and go to ACK.
  - ACK: on `fall`, sample synchronized data. 0 means ACK and goes to WAIT_IDLE; 1 means NACK, which pulses `error` and goes to WAIT_IDLE with `nack` set.
  - WAIT_IDLE: once synchronized clock and data are both 1, pulse `done` (unless `nack`) and go to IDLE.
- Timeout applies in RTS, SHIFT, STOP, ACK and WAIT_IDLE:
  - The counter resets on every edge of the synchronized clock (rising or falling).
  - If it reaches `TIMEOUT_CYCLES`, pulse `error`, set both oe outputs to 0 and go to IDLE.
  - `done` and `error` are never asserted together.
- `tx_valid` while busy is ignored; the byte is not queued.
- Reset mid-frame releases both lines immediately. The device will time out on its side.

## Timing
- Reset values:
  - `tx_ready=1`, `busy=0`, `done=0`, `error=0`, `ps2_clk_oe=0`, `ps2_data_oe=0`.
  - State is IDLE; the counter and shift register are 0.
- Accept happens in cycle N. `busy=1` and `ps2_clk_oe=1` in cycle N+1 (registered outputs).
- `ps2_data_oe` rises `INHIBIT_CYCLES` cycles after `ps2_clk_oe` rises. `ps2_clk_oe` falls 1 cycle after that.
- Data changes 3 cycles after the pin's falling edge: 2 synchronizer cycles plus 1 register cycle. This is well inside the 5 µs device setup window.
- `done` is high 3 cycles after both pins are high.

## Configuration
- `PS2_TX_ACK_CHECK_EN`
  - Defined: the ACK state and NACK error exist as described above.
  - Undefined: STOP goes directly to WAIT_IDLE. The 11th falling edge is not inspected and `error` comes only from timeout. This is for devices that omit the ACK.

## Structure
- Package `ps2_pkg` holds:
  - the state enum `ps2_tx_state_t`;
  - localparams for frame length 11 and bit index width;
  - the function `odd_parity(byte)`.
- Sub-module `ps2_sync_edge`: 2-FF synchronizer plus falling/rising-edge detector, instantiated once per line. The PS/2 receiver can reuse it.
- Model the test bench device with a 40 µs clock period, using reduced `CLK_HZ` for speed.

## Test plan
- Send 0xED, device ACKs:
  - Device samples start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - `done` pulses once; `error` stays 0.
- Send 0xF4: sampled parity = 0; `done` pulses.
- Device drives data high on the 11th edge with the macro defined: `error` pulses once and `done` stays 0. With the macro undefined, `done` pulses.
- Device stops clocking after bit 3:
  - After `TIMEOUT_CYCLES`, `error` pulses, both oe outputs are 0 and `tx_ready=1`.
- `tx_valid` with 0x55 during a transfer of 0x00: 0x55 is never transmitted. 0x00 completes with parity 1.
- `rst_n` asserted in SHIFT: oe outputs are 0 asynchronously. After release, state is IDLE and 0xFF sends correctly.
